ccsds123_out_buffer: RTL and testbench

//   Output stage that sits directly downstream of ccsds123_top.

---
 rtl/ccsds123_out_buffer.sv | 124 ++++++++++++
 tb/tb_ccsds123_out_buffer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ccsds123_out_buffer.sv
// Output buffer behind ccsds123_top: FIFO of {tlast, word}, re-emitted as OUT_WIDTH-bit AXI-Stream beats.
// Optional feature: define CCSDS123_OUT_BUFFER_DROP_CNT_EN to add a saturating drop_count output.
module ccsds123_out_buffer #(
    parameter int BUS_WIDTH = 64,
    parameter int OUT_WIDTH = 32,
    parameter int DEPTH_LOG = 5
) (
    input  logic                 clk,
    input  logic                 aresetn,
    input  logic [BUS_WIDTH-1:0] in_tdata,
    input  logic                 in_tvalid,
    input  logic                 in_tlast,
    output logic [OUT_WIDTH-1:0] out_tdata,
    output logic                 out_tvalid,
    input  logic                 out_tready,
    output logic                 out_tlast,
    output logic                 overflow,
`ifdef CCSDS123_OUT_BUFFER_DROP_CNT_EN
    output logic [15:0]          drop_count,
`endif
    output logic [DEPTH_LOG:0]   level
);

    localparam int RATIO  = BUS_WIDTH / OUT_WIDTH;
    localparam int DEPTH  = 2 ** DEPTH_LOG;
    localparam int BEAT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [BEAT_W-1:0]  LAST_BEAT = BEAT_W'(RATIO - 1);
    localparam logic [DEPTH_LOG:0] PTR_MSB   = {1'b1, {DEPTH_LOG{1'b0}}};

    if (BUS_WIDTH % OUT_WIDTH != 0) begin : g_width_check
        $error("BUS_WIDTH must be a multiple of OUT_WIDTH");
    end

    logic [BUS_WIDTH:0]  mem [DEPTH];
    logic [DEPTH_LOG:0]  wptr;
    logic [DEPTH_LOG:0]  rptr;
    logic [DEPTH_LOG:0]  rptr_nxt;
    logic [BEAT_W-1:0]   beat;
    logic [BEAT_W-1:0]   beat_nxt;
    logic [BUS_WIDTH:0]  head_nxt;
    logic                full;
    logic                accept;
    logic                pop;
    logic                wr;
    logic                drop;
    logic                load;
    logic                avail;

    assign full   = (wptr ^ rptr) == PTR_MSB;
    assign accept = out_tvalid && out_tready;
    assign pop    = accept && (beat == LAST_BEAT);
    assign wr     = in_tvalid && (!full || pop);
    assign drop   = in_tvalid && full && !pop;
    assign load   = !out_tvalid || out_tready;

    // The head word stays in the FIFO until its last beat is taken; the
    // output register is refilled from the post-pop head so words flow back to back.
    always_comb begin
        rptr_nxt = rptr;
        beat_nxt = beat;
        if (pop) begin
            rptr_nxt = rptr + 1'b1;
            beat_nxt = '0;
        end else if (accept) begin
            beat_nxt = beat + 1'b1;
        end
    end

    assign avail    = (rptr_nxt != wptr);
    assign head_nxt = mem[rptr_nxt[DEPTH_LOG-1:0]];

    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wptr[DEPTH_LOG-1:0]] <= {in_tlast, in_tdata};
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            wptr       <= '0;
            rptr       <= '0;
            beat       <= '0;
            out_tvalid <= 1'b0;
            out_tdata  <= '0;
            out_tlast  <= 1'b0;
            overflow   <= 1'b0;
            level      <= '0;
        end else begin
            rptr <= rptr_nxt;
            beat <= beat_nxt;
            if (wr) begin
                wptr <= wptr + 1'b1;
            end
            if (load) begin
                out_tvalid <= avail;
                if (avail) begin
                    out_tdata <= head_nxt[beat_nxt*OUT_WIDTH +: OUT_WIDTH];
                    out_tlast <= head_nxt[BUS_WIDTH] && (beat_nxt == LAST_BEAT);
                end else begin
                    out_tlast <= 1'b0;
                end
            end
            if (drop) begin
                overflow <= 1'b1;
            end
            case ({wr, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

`ifdef CCSDS123_OUT_BUFFER_DROP_CNT_EN
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            drop_count <= '0;
        end else if (drop && drop_count != 16'hFFFF) begin
            drop_count <= drop_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ccsds123_out_buffer.sv
// Directed bench for ccsds123_out_buffer: latency, full/overflow, full+pop, paced random-ready stream, async reset.
// Words are built so that beat k of the stream carries value k, which makes ordering checks trivial.
module tb_ccsds123_out_buffer;

    localparam int BW = 64;
    localparam int OW = 32;
    localparam int DL = 5;

    logic          clk = 1'b0;
    logic          aresetn = 1'b0;
    logic [BW-1:0] in_tdata = '0;
    logic          in_tvalid = 1'b0;
    logic          in_tlast = 1'b0;
    logic [OW-1:0] out_tdata;
    logic          out_tvalid;
    logic          out_tready = 1'b0;
    logic          out_tlast;
    logic          overflow;
    logic [DL:0]   level;
`ifdef CCSDS123_OUT_BUFFER_DROP_CNT_EN
    logic [15:0]   drop_count;
`endif

    int n_vec = 0;
    int n_err = 0;

    ccsds123_out_buffer #(.BUS_WIDTH(BW), .OUT_WIDTH(OW), .DEPTH_LOG(DL)) dut (
        .clk        (clk),
        .aresetn    (aresetn),
        .in_tdata   (in_tdata),
        .in_tvalid  (in_tvalid),
        .in_tlast   (in_tlast),
        .out_tdata  (out_tdata),
        .out_tvalid (out_tvalid),
        .out_tready (out_tready),
        .out_tlast  (out_tlast),
        .overflow   (overflow),
`ifdef CCSDS123_OUT_BUFFER_DROP_CNT_EN
        .drop_count (drop_count),
`endif
        .level      (level)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        aresetn    = 1'b0;
        in_tvalid  = 1'b0;
        in_tlast   = 1'b0;
        in_tdata   = '0;
        out_tready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        aresetn = 1'b1;
        tick();
    endtask

    task automatic write_word(input logic [63:0] d, input logic last);
        in_tdata  = d;
        in_tlast  = last;
        in_tvalid = 1'b1;
        tick();
        in_tvalid = 1'b0;
        in_tlast  = 1'b0;
    endtask

    function automatic logic [63:0] cword(input int i);
        return {32'(2 * i + 1), 32'(2 * i)};
    endfunction

    // Expects beats start..start+count-1 back to back, tlast only on value last_at.
    task automatic drain(input string tag, input int start, input int count, input int last_at);
        out_tready = 1'b1;
        for (int k = 0; k < count; k++) begin
            check_val(tag, {out_tvalid, out_tlast, out_tdata},
                      {1'b1, (start + k == last_at), 32'(start + k)});
            tick();
        end
        out_tready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_beat;
        int cyc;

        // reset values and single-word latency
        do_reset();
        check_val("rst_tvalid", out_tvalid, 0);
        check_val("rst_tlast", out_tlast, 0);
        check_val("rst_tdata", out_tdata, 0);
        check_val("rst_overflow", overflow, 0);
        check_val("rst_level", level, 0);

        out_tready = 1'b1;
        write_word(64'h1122334455667788, 1'b1);
        check_val("t1_latency", out_tvalid, 0);
        check_val("t1_level1", level, 1);
        tick();
        check_val("t1_beat0", {out_tvalid, out_tlast, out_tdata}, {1'b1, 1'b0, 32'h55667788});
        tick();
        check_val("t1_beat1", {out_tvalid, out_tlast, out_tdata}, {1'b1, 1'b1, 32'h11223344});
        tick();
        check_val("t1_empty", out_tvalid, 0);
        check_val("t1_level0", level, 0);

        // fill, overflow, drain
        do_reset();
        for (int i = 0; i < 32; i++) write_word(cword(i), i == 31);
        check_val("t2_level_full", level, 32);
        check_val("t2_no_overflow", overflow, 0);
        write_word(64'hDEADBEEF0BADF00D, 1'b0);
        check_val("t2_overflow", overflow, 1);
        check_val("t2_level_kept", level, 32);
        drain("t2_drain", 0, 64, 63);
        check_val("t2_end_tvalid", out_tvalid, 0);
        check_val("t2_end_level", level, 0);
        check_val("t2_sticky", overflow, 1);

        // full FIFO with simultaneous pop and write
        do_reset();
        for (int i = 0; i < 32; i++) write_word(cword(i), i == 31);
        out_tready = 1'b1;
        tick();
        write_word(cword(32), 1'b0);
        out_tready = 1'b0;
        check_val("t3_level", level, 32);
        check_val("t3_overflow", overflow, 0);
        drain("t3_drain", 2, 64, 63);
        check_val("t3_end_level", level, 0);

        // paced stream with random backpressure
        do_reset();
        exp_beat = 0;
        cyc = 0;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    write_word(cword(i), i == 999);
                    repeat (4) tick();
                end
            end
            begin
                while (exp_beat < 2000 && cyc < 10000) begin
                    out_tready = 1'($urandom_range(0, 1));
                    if (out_tvalid) begin
                        check_val("t4_beat", {out_tlast, out_tdata}, {(exp_beat == 1999), 32'(exp_beat)});
                        if (out_tready) exp_beat++;
                    end
                    tick();
                    cyc++;
                end
            end
        join
        out_tready = 1'b0;
        check_val("t4_all_beats", exp_beat, 2000);
        check_val("t4_overflow", overflow, 0);

        // mid-beat asynchronous reset
        do_reset();
        for (int i = 0; i < 10; i++) write_word(cword(100 + i), 1'b0);
        out_tready = 1'b1;
        tick();
        out_tready = 1'b0;
        #2;
        aresetn = 1'b0;
        #1;
        check_val("t5_async_tvalid", out_tvalid, 0);
        check_val("t5_async_level", level, 0);
        repeat (2) @(posedge clk);
        #1;
        aresetn = 1'b1;
        tick();
        check_val("t5_post_tvalid", out_tvalid, 0);
        write_word(64'h000000BB000000AA, 1'b1);
        out_tready = 1'b1;
        tick();
        check_val("t5_first0", {out_tvalid, out_tlast, out_tdata}, {1'b1, 1'b0, 32'hAA});
        tick();
        check_val("t5_first1", {out_tvalid, out_tlast, out_tdata}, {1'b1, 1'b1, 32'hBB});
        tick();
        out_tready = 1'b0;
        check_val("t5_level", level, 0);

`ifdef CCSDS123_OUT_BUFFER_DROP_CNT_EN
        do_reset();
        check_val("t6_rst_count", drop_count, 0);
        for (int i = 0; i < 32; i++) write_word(cword(i), 1'b0);
        for (int i = 0; i < 5; i++) write_word(cword(40 + i), 1'b0);
        check_val("t6_drop_count", drop_count, 5);
        check_val("t6_overflow", overflow, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
